// File: rtl/register_bank_8x_if.sv
// Bundle between the register bank and its neighbours: ALU write-back,
// issue/decode operand selects, and the register outputs to the operand muxes.
interface register_bank_8x_if #(
  parameter int unsigned WORD_SIZE = 8
);

  // Write-back from the ALU output demux
  logic                 wr_en;
  logic [3:0]           wr_sel;
  logic [WORD_SIZE-1:0] wr_data;

  // Issue / decode
  logic                 issue_en;
  logic [3:0]           issue_sel;
  logic [2:0]           src_sel_a;
  logic [3:0]           src_sel_b;

  // Register contents to the side-A / side-B operand muxes
  logic [WORD_SIZE-1:0] q_a;
  logic [WORD_SIZE-1:0] q_b;
  logic [WORD_SIZE-1:0] q_c;
  logic [WORD_SIZE-1:0] q_d;
  logic [WORD_SIZE-1:0] q_e;
  logic [WORD_SIZE-1:0] q_f;
  logic [WORD_SIZE-1:0] q_g;
  logic [WORD_SIZE-1:0] q_h;

  // Scoreboard view
  logic [7:0]           pending;
  logic                 stall;

  // Pipeline side: drives write-back and issue, observes the bank
  modport master (
    output wr_en, wr_sel, wr_data,
    output issue_en, issue_sel, src_sel_a, src_sel_b,
    input  q_a, q_b, q_c, q_d, q_e, q_f, q_g, q_h,
    input  pending, stall
  );

  // Register bank side
  modport slave (
    input  wr_en, wr_sel, wr_data,
    input  issue_en, issue_sel, src_sel_a, src_sel_b,
    output q_a, q_b, q_c, q_d, q_e, q_f, q_g, q_h,
    output pending, stall
  );

endinterface

// File: rtl/register_bank_8x.sv
// Eight-entry register bank (A..H) with a pending-write scoreboard and stall.
// Optional same-cycle write-back forwarding is enabled by defining
// REGBANK_BYPASS_EN; without it the outputs show the stored registers only.
module register_bank_8x #(
  parameter int unsigned WORD_SIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  register_bank_8x_if.slave bus
);

  localparam int unsigned NREG  = 8;
  localparam int unsigned SEL_W = 4;

  typedef logic [WORD_SIZE-1:0] word_t;

  word_t [NREG-1:0] regs_q;
  word_t [NREG-1:0] regs_d;
  word_t [NREG-1:0] q_view;
  logic  [NREG-1:0] pending_q;
  logic  [NREG-1:0] pending_d;
  logic  [NREG-1:0] wr_hit;
  logic  [NREG-1:0] set_hit;
  logic  [NREG-1:0] stall_mask;
  logic             dep_a;
  logic             dep_b;

  // One-hot decode of write-back target and issue destination; codes >= 8 hit nothing
  always_comb begin
    wr_hit  = '0;
    set_hit = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      wr_hit[i]  = bus.wr_en    && (bus.wr_sel    == SEL_W'(i));
      set_hit[i] = bus.issue_en && (bus.issue_sel == SEL_W'(i));
    end
  end

  // Next state: write data into the target, issue sets pending with priority over clear
  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    for (int i = 0; i < int'(NREG); i++) begin
      if (wr_hit[i]) begin
        regs_d[i] = bus.wr_data;
      end
      if (set_hit[i]) begin
        pending_d[i] = 1'b1;
      end else if (wr_hit[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q    <= '0;
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

`ifdef REGBANK_BYPASS_EN
  // Forward the write-back value and hide pending bits that retire this cycle,
  // unless the same register is being reissued right now
  always_comb begin
    q_view     = regs_q;
    stall_mask = pending_q & ~(wr_hit & ~set_hit);
    for (int i = 0; i < int'(NREG); i++) begin
      if (wr_hit[i]) begin
        q_view[i] = bus.wr_data;
      end
    end
  end
`else
  // No forwarding: outputs and stall use stored state only
  always_comb begin
    q_view     = regs_q;
    stall_mask = pending_q;
  end
`endif

  // Operand hazard check; side-B codes 8..15 (IMM8 / NC) never depend on a register
  always_comb begin
    dep_a = stall_mask[bus.src_sel_a];
    dep_b = 1'b0;
    if (!bus.src_sel_b[3]) begin
      dep_b = stall_mask[bus.src_sel_b[2:0]];
    end
  end

  assign bus.stall   = dep_a | dep_b;
  assign bus.pending = pending_q;

  assign bus.q_a = q_view[0];
  assign bus.q_b = q_view[1];
  assign bus.q_c = q_view[2];
  assign bus.q_d = q_view[3];
  assign bus.q_e = q_view[4];
  assign bus.q_f = q_view[5];
  assign bus.q_g = q_view[6];
  assign bus.q_h = q_view[7];

endmodule

// File: tb/tb_register_bank_8x.sv
// Directed bench for register_bank_8x; expectations follow the build's
// REGBANK_BYPASS_EN setting.
module tb_register_bank_8x;

  localparam int unsigned WORD_SIZE = 8;

`ifdef REGBANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;

  register_bank_8x_if #(.WORD_SIZE(WORD_SIZE)) bif ();

  register_bank_8x #(.WORD_SIZE(WORD_SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  int n_tests;
  int n_fail;
  logic [7:0] exp_q [8];
  logic [7:0] exp_pend;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dut_q(input int i);
    case (i)
      0: return bif.q_a;
      1: return bif.q_b;
      2: return bif.q_c;
      3: return bif.q_d;
      4: return bif.q_e;
      5: return bif.q_f;
      6: return bif.q_g;
      default: return bif.q_h;
    endcase
  endfunction

  // Compare all registers and the scoreboard against the bench's expected state
  task automatic check_bank(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s q[%0d]", tag, i), 32'(dut_q(i)), 32'(exp_q[i]));
    end
    check($sformatf("%s pending", tag), 32'(bif.pending), 32'(exp_pend));
  endtask

  task automatic idle();
    bif.wr_en    = 1'b0;
    bif.wr_sel   = 4'd8;
    bif.wr_data  = 8'h00;
    bif.issue_en = 1'b0;
    bif.issue_sel = 4'd8;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 8; i++) exp_q[i] = 8'h00;
    exp_pend = 8'h00;

    rst_n = 1'b0;
    idle();
    bif.src_sel_a = 3'd0;
    bif.src_sel_b = 4'd8;

    // 1. Reset
    #12;
    check_bank("reset");
    check("reset stall", 32'(bif.stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2. Write D = A5
    @(negedge clk);
    bif.wr_en = 1'b1; bif.wr_sel = 4'd3; bif.wr_data = 8'hA5;
    #1;
    check("wr pre-edge q_d", 32'(bif.q_d), BYP ? 32'h00A5 : 32'h0000);
    after_edge();
    exp_q[3] = 8'hA5;
    check_bank("wr D");

    // 3. NC write
    @(negedge clk);
    bif.wr_sel = 4'd9; bif.wr_data = 8'hFF;
    after_edge();
    check_bank("nc write");
    // wr_en low with a valid target writes nothing
    @(negedge clk);
    bif.wr_en = 1'b0; bif.wr_sel = 4'd0; bif.wr_data = 8'hEE;
    after_edge();
    check_bank("wr_en low");

    // 4. Hazard on C
    @(negedge clk);
    idle();
    bif.issue_en = 1'b1; bif.issue_sel = 4'd2; bif.src_sel_a = 3'd2;
    #1;
    check("issue pre-edge stall", 32'(bif.stall), 32'd0);
    after_edge();
    exp_pend = 8'h04;
    check("issue pending", 32'(bif.pending), 32'(exp_pend));
    @(negedge clk);
    idle();
    #1;
    check("hazard A stall", 32'(bif.stall), 32'd1);
    bif.src_sel_a = 3'd0; bif.src_sel_b = 4'd2;
    #1;
    check("hazard B stall", 32'(bif.stall), 32'd1);
    bif.src_sel_b = 4'd10;
    #1;
    check("NC B stall", 32'(bif.stall), 32'd0);
    bif.src_sel_b = 4'd8;
    #1;
    check("IMM8 B stall", 32'(bif.stall), 32'd0);
    @(negedge clk);
    bif.src_sel_a = 3'd2;
    bif.wr_en = 1'b1; bif.wr_sel = 4'd2; bif.wr_data = 8'h11;
    #1;
    check("wb pre-edge stall", 32'(bif.stall), BYP ? 32'd0 : 32'd1);
    check("wb pre-edge q_c", 32'(bif.q_c), BYP ? 32'h11 : 32'h00);
    after_edge();
    exp_q[2] = 8'h11; exp_pend = 8'h00;
    check_bank("wb C");
    check("wb stall", 32'(bif.stall), 32'd0);

    // 5. Collision on F
    @(negedge clk);
    idle();
    bif.issue_en = 1'b1; bif.issue_sel = 4'd5; bif.src_sel_a = 3'd5;
    after_edge();
    exp_pend = 8'h20;
    @(negedge clk);
    bif.wr_en = 1'b1; bif.wr_sel = 4'd5; bif.wr_data = 8'h55;
    #1;
    check("collide pre-edge stall", 32'(bif.stall), 32'd1);
    after_edge();
    exp_q[5] = 8'h55;
    check_bank("collide");
    check("collide stall", 32'(bif.stall), 32'd1);
    @(negedge clk);
    bif.issue_en = 1'b0; bif.wr_data = 8'h66;
    #1;
    check("retire pre-edge stall", 32'(bif.stall), BYP ? 32'd0 : 32'd1);
    after_edge();
    exp_q[5] = 8'h66; exp_pend = 8'h00;
    check_bank("retire F");

    // Double issue to B, one write-back clears it; issue to code >= 8 ignored
    @(negedge clk);
    idle();
    bif.issue_en = 1'b1; bif.issue_sel = 4'd1;
    after_edge();
    after_edge();
    exp_pend = 8'h02;
    @(negedge clk);
    bif.issue_sel = 4'd12;
    after_edge();
    check("issue none pending", 32'(bif.pending), 32'(exp_pend));
    @(negedge clk);
    idle();
    bif.wr_en = 1'b1; bif.wr_sel = 4'd1; bif.wr_data = 8'h77;
    after_edge();
    exp_q[1] = 8'h77; exp_pend = 8'h00;
    check_bank("double issue");

    // 6. Bypass on H
    @(negedge clk);
    bif.wr_sel = 4'd7; bif.wr_data = 8'h3C;
    #1;
    check("bypass pre-edge q_h", 32'(bif.q_h), BYP ? 32'h3C : 32'h00);
    after_edge();
    exp_q[7] = 8'h3C;
    check_bank("wr H");

    // 7. Async reset mid-cycle with an outstanding write-back on E
    @(negedge clk);
    idle();
    bif.issue_en = 1'b1; bif.issue_sel = 4'd4; bif.src_sel_a = 3'd4;
    after_edge();
    check("pre-reset pending", 32'(bif.pending), 32'h10);
    @(negedge clk);
    idle();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) exp_q[i] = 8'h00;
    exp_pend = 8'h00;
    check_bank("async reset");
    check("async reset stall", 32'(bif.stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bif.wr_en = 1'b1; bif.wr_sel = 4'd4; bif.wr_data = 8'h99;
    after_edge();
    exp_q[4] = 8'h99;
    check_bank("post-reset wr");
    check("post-reset stall", 32'(bif.stall), 32'd0);

    @(negedge clk);
    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
